// File: rtl/poly_music_core.sv
// N-voice music player core: play/next control, tempo beat generator, voice allocator
// with per-voice beat countdown, and a saturating mixer. Optional macro: VOICE_STEAL_EN.
module poly_music_core #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 16,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6,
   parameter int BEAT_W     = 10,
   parameter int SONG_W     = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           play_button,
   input  logic                           next_button,
   input  logic                           song_done,
   input  logic                           new_frame,
   input  logic [BEAT_W-1:0]              tempo_div,
   input  logic                           note_valid,
   input  logic [NOTE_W-1:0]              note,
   input  logic [DUR_W-1:0]               duration,
   output logic                           note_ready,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
   output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
   output logic [NUM_VOICES-1:0]          voice_load,
   output logic [NUM_VOICES-1:0]          voice_active,
   output logic                           play,
   output logic                           reset_player,
   output logic [SONG_W-1:0]              song,
   output logic                           beat,
   output logic                           new_sample_generated,
   output logic [SAMPLE_W-1:0]            sample_out
);

   typedef enum logic {PAUSED, PLAYING} state_t;

   localparam int SUM_W = SAMPLE_W + 3;
   localparam logic signed [SUM_W-1:0] SAT_MAX = {4'b0000, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {4'b1111, {(SAMPLE_W-1){1'b0}}};

   state_t                      state;
   logic                        prev_frame;
   logic                        frame_edge;
   logic                        song_step;
   logic [BEAT_W-1:0]           beat_cnt;
   logic [BEAT_W-1:0]           tdiv_eff;
   logic signed [SAMPLE_W-1:0]  mix_reg;
   logic signed [SAMPLE_W-1:0]  mix_next;
   logic signed [SUM_W-1:0]     mix_sum;
   logic [DUR_W-1:0]            remain [NUM_VOICES];
   logic [NUM_VOICES-1:0]       idle;
   logic [NUM_VOICES-1:0]       idle_oh;
   logic [NUM_VOICES-1:0]       pick_oh;
   logic                        any_idle;
   logic                        accept;

   assign song_step  = next_button | song_done;
   assign frame_edge = new_frame & ~prev_frame;
   assign tdiv_eff   = (tempo_div == '0) ? BEAT_W'(1) : tempo_div;
   assign idle       = ~voice_active;
   assign any_idle   = |idle;
   // Two's-complement trick isolates the lowest set bit: the lowest-index idle voice.
   assign idle_oh    = idle & (~idle + NUM_VOICES'(1));

`ifdef VOICE_STEAL_EN
   logic [NUM_VOICES-1:0] steal_oh;
   logic [DUR_W-1:0]      best_rem;
   logic                  found;

   // Strict less-than keeps the lowest index among voices tied on remain.
   always_comb begin
      steal_oh = '0;
      best_rem = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!found || remain[i] < best_rem) begin
            best_rem    = remain[i];
            steal_oh    = '0;
            steal_oh[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign note_ready = play & ~reset_player;
   assign pick_oh    = any_idle ? idle_oh : steal_oh;
`else
   assign note_ready = play & any_idle & ~reset_player;
   assign pick_oh    = idle_oh;
`endif

   // Zero-duration notes are handshaken away without touching any voice.
   assign accept = note_valid & note_ready & (duration != '0);

   // NOTE: blocking assignments are right here; this block is combinational and accumulates.
   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (voice_active[i])
            mix_sum = mix_sum + SUM_W'($signed(voice_samples[i*SAMPLE_W +: SAMPLE_W]));
      end
      if (mix_sum > SAT_MAX)
         mix_next = SAT_MAX[SAMPLE_W-1:0];
      else if (mix_sum < SAT_MIN)
         mix_next = SAT_MIN[SAMPLE_W-1:0];
      else
         mix_next = mix_sum[SAMPLE_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= PAUSED;
         play                 <= 1'b0;
         song                 <= '0;
         reset_player         <= 1'b0;
         prev_frame           <= 1'b0;
         new_sample_generated <= 1'b0;
         sample_out           <= '0;
         mix_reg              <= '0;
         beat_cnt             <= '0;
         beat                 <= 1'b0;
         voice_active         <= '0;
         voice_load           <= '0;
         voice_note           <= '0;
         // NOTE: remain is a small register array and is cleared so no countdown starts from X.
         for (int i = 0; i < NUM_VOICES; i++)
            remain[i] <= '0;
      end else begin
         prev_frame           <= new_frame;
         new_sample_generated <= frame_edge;
         mix_reg              <= mix_next;
         reset_player         <= song_step;
         beat                 <= 1'b0;
         if (frame_edge)
            sample_out <= play ? mix_reg : '0;

         // Song change outranks a coincident play toggle.
         if (song_step) begin
            song  <= song + SONG_W'(1);
            state <= PAUSED;
            play  <= 1'b0;
         end else if (play_button) begin
            state <= (state == PAUSED) ? PLAYING : PAUSED;
            play  <= (state == PAUSED);
         end

         if (reset_player) begin
            beat_cnt <= '0;
         end else if (new_sample_generated && play) begin
            if (beat_cnt == tdiv_eff - BEAT_W'(1)) begin
               beat_cnt <= '0;
               beat     <= 1'b1;
            end else begin
               beat_cnt <= beat_cnt + BEAT_W'(1);
            end
         end

         // A fresh load takes priority over a coincident beat for that voice.
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (song_step) begin
               voice_active[i]                  <= 1'b0;
               voice_load[i]                    <= 1'b0;
               remain[i]                        <= '0;
               voice_note[i*NOTE_W +: NOTE_W]   <= '0;
            end else if (accept && pick_oh[i]) begin
               voice_active[i]                  <= 1'b1;
               voice_load[i]                    <= 1'b1;
               remain[i]                        <= duration;
               voice_note[i*NOTE_W +: NOTE_W]   <= note;
            end else begin
               voice_load[i] <= 1'b0;
               if (beat && voice_active[i]) begin
                  remain[i] <= remain[i] - DUR_W'(1);
                  if (remain[i] == DUR_W'(1))
                     voice_active[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_poly_music_core.sv
// Scoreboard bench for poly_music_core: stimulus pushes expected samples and voice loads,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_poly_music_core;

   localparam int NV = 4;
   localparam int SW = 16;
   localparam int NW = 6;
   localparam int DW = 6;
   localparam int BW = 10;
   localparam int GW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              play_button, next_button, song_done, new_frame;
   logic [BW-1:0]     tempo_div;
   logic              note_valid;
   logic [NW-1:0]     note;
   logic [DW-1:0]     duration;
   logic              note_ready;
   logic [NV*SW-1:0]  voice_samples;
   logic [NV*NW-1:0]  voice_note;
   logic [NV-1:0]     voice_load, voice_active;
   logic              play, reset_player, beat, new_sample_generated;
   logic [GW-1:0]     song;
   logic [SW-1:0]     sample_out;

   poly_music_core #(
      .NUM_VOICES(NV), .SAMPLE_W(SW), .NOTE_W(NW), .DUR_W(DW), .BEAT_W(BW), .SONG_W(GW)
   ) dut (
      .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
      .song_done(song_done), .new_frame(new_frame), .tempo_div(tempo_div),
      .note_valid(note_valid), .note(note), .duration(duration), .note_ready(note_ready),
      .voice_samples(voice_samples), .voice_note(voice_note), .voice_load(voice_load),
      .voice_active(voice_active), .play(play), .reset_player(reset_player), .song(song),
      .beat(beat), .new_sample_generated(new_sample_generated), .sample_out(sample_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int nsg_seen = 0;
   int beat_seen = 0;
   int samp_q[$];
   logic [NV+NW-1:0] load_q[$];

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a sample or a voice load appears.
   always @(negedge clk) begin
      if (new_sample_generated) begin
         nsg_seen++;
         if (samp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sample_unexpected: got %0d expected none", $signed(sample_out));
         end else begin
            check("sample_out", $signed(sample_out), samp_q.pop_front());
         end
      end
      if (beat) beat_seen++;
      if (|voice_load) begin
         if (load_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL load_unexpected: got %b expected none", voice_load);
         end else begin
            logic [NV+NW-1:0] e;
            e = load_q.pop_front();
            check("voice_load", voice_load, e[NV+NW-1:NW]);
            for (int v = 0; v < NV; v++)
               if (e[NW+v]) check("voice_note", voice_note[v*NW +: NW], e[NW-1:0]);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
      voice_samples = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
   endtask

   // One codec frame; exp is the sample the monitor must see for it.
   task automatic frame(input int exp);
      samp_q.push_back(exp);
      @(posedge clk); #1 new_frame = 1'b1;
      repeat (2) @(posedge clk);
      #1 new_frame = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic press(input int which);
      @(posedge clk); #1;
      case (which)
         0: play_button = 1'b1;
         1: next_button = 1'b1;
         default: song_done = 1'b1;
      endcase
      @(posedge clk); #1;
      play_button = 1'b0; next_button = 1'b0; song_done = 1'b0;
   endtask

   task automatic send_note(input logic [NW-1:0] n, input logic [DW-1:0] d,
                            input logic [NV-1:0] exp_oh);
      logic got;
      if (d != 0) load_q.push_back({exp_oh, n});
      @(posedge clk); #1;
      note = n; duration = d; note_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (note_ready) got = 1'b1;
      end
      check("note_ready_accept", got, 1);
      @(posedge clk); #1 note_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen_ready;
      reset = 1'b1; play_button = 0; next_button = 0; song_done = 0; new_frame = 0;
      tempo_div = 4; note_valid = 0; note = 0; duration = 0;
      set_samples(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_play", play, 0);
      check("rst_song", song, 0);
      check("rst_sample", sample_out, 0);
      check("rst_active", voice_active, 0);
      check("rst_ready", note_ready, 0);
      check("rst_reset_player", reset_player, 0);

      press(0); @(negedge clk); check("play_on", play, 1); check("song_0", song, 0);
      press(0); @(negedge clk); check("play_off", play, 0);
      press(0); @(negedge clk); check("play_on2", play, 1);

      // Tempo 4: every fourth frame is a beat.
      nsg_seen = 0; beat_seen = 0;
      for (int f = 0; f < 12; f++) frame(0);
      check("nsg_count_t4", nsg_seen, 12);
      check("beat_count_t4", beat_seen, 3);

      tempo_div = 0; beat_seen = 0;
      for (int f = 0; f < 3; f++) frame(0);
      check("beat_count_t0", beat_seen, 3);

      // Allocation and countdown, one beat per frame.
      tempo_div = 1;
      send_note(6'd10, 6'd2, 4'b0001);
      send_note(6'd11, 6'd1, 4'b0010);
      send_note(6'd12, 6'd0, 4'b0000);
      check("active_after_alloc", voice_active, 4'b0011);
      frame(0);
      check("active_after_beat1", voice_active, 4'b0001);
      frame(0);
      check("active_after_beat2", voice_active, 4'b0000);

      // Mixer saturation with all four voices busy.
      tempo_div = 1000;
      set_samples(30000, 30000, 30000, 30000);
      send_note(6'd20, 6'd63, 4'b0001);
      send_note(6'd21, 6'd63, 4'b0010);
      send_note(6'd22, 6'd63, 4'b0100);
      send_note(6'd23, 6'd63, 4'b1000);
      check("active_full", voice_active, 4'b1111);
      frame(32767);
      set_samples(-30000, -30000, -30000, -30000);
      frame(-32768);
      set_samples(100, -50, 7, 1);
      frame(58);
      press(0); @(negedge clk); check("paused", play, 0);
      frame(0);
      press(0); @(negedge clk); check("replay", play, 1);

      // next_button and play_button together while playing.
      @(posedge clk); #1 next_button = 1'b1; play_button = 1'b1;
      @(posedge clk); #1 next_button = 1'b0; play_button = 1'b0;
      @(negedge clk);
      check("next_song", song, 1);
      check("next_play", play, 0);
      check("next_reset_player", reset_player, 1);
      check("next_voices_clear", voice_active, 0);
      @(negedge clk);
      check("reset_player_pulse", reset_player, 0);

      press(0);
      send_note(6'd30, 6'd5, 4'b0001);
      send_note(6'd31, 6'd2, 4'b0010);
      send_note(6'd32, 6'd2, 4'b0100);
      send_note(6'd33, 6'd7, 4'b1000);
`ifdef VOICE_STEAL_EN
      send_note(6'd34, 6'd3, 4'b0010);
      check("steal_active", voice_active, 4'b1111);
`else
      @(posedge clk); #1 note = 6'd34; duration = 6'd3; note_valid = 1'b1;
      seen_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (note_ready) seen_ready = 1'b1;
      end
      check("full_not_ready", seen_ready, 0);
      @(posedge clk); #1 note_valid = 1'b0;
`endif

      press(1); press(1);
      @(negedge clk); check("song_3", song, 3);
      press(2);
      @(negedge clk); check("song_wrap", song, 0);

      repeat (5) @(posedge clk);
      check("sample_q_drained", samp_q.size(), 0);
      check("load_q_drained", load_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/poly_music_core.md
Name: poly_music_core

Overview:
- Parametrised successor to the single-voice music player top level.
- Combines play/next control, a tempo-programmable beat generator, an N-voice note allocator with per-voice duration countdown, and a saturating sample mixer synced to the codec frame strobe.
- Sits between the song reader, which supplies notes through a valid/ready handshake, and N external voice sample generators.
- Drives the final codec sample.

Parameters:
- NUM_VOICES, 4: number of simultaneous voices, 1..8.
- SAMPLE_W, 16: signed sample width, for both voice inputs and sample_out.
- NOTE_W, 6: note code width.
- DUR_W, 6: duration width, in beats.
- BEAT_W, 10: width of the tempo divider.
- SONG_W, 2: song index width; songs wrap modulo 2^SONG_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state.
- play_button  in  1  one-cycle pulse; toggles play/pause.
- next_button  in  1  one-cycle pulse; advances to the next song.
- song_done  in  1  one-cycle pulse from the song reader at end of song.
- new_frame  in  1  raw codec frame signal, level.
- tempo_div  in  BEAT_W  samples per beat; a value of 0 is treated as 1.
- note_valid  in  1  note offer from the song reader.
- note  in  NOTE_W  note code.
- duration  in  DUR_W  note length in beats.
- note_ready  out  1  note accepted when note_valid & note_ready.
- voice_samples  in  NUM_VOICES*SAMPLE_W  packed signed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- voice_note  out  NUM_VOICES*NOTE_W  packed note per voice.
- voice_load  out  NUM_VOICES  one-cycle load pulse per voice.
- voice_active  out  NUM_VOICES  voice busy flags.
- play  out  1  playing state.
- reset_player  out  1  one-cycle pulse clearing downstream song logic.
- song  out  SONG_W  current song index.
- beat  out  1  one-cycle beat pulse.
- new_sample_generated  out  1  one-cycle pulse per codec frame.
- sample_out  out  SAMPLE_W  sample presented to the codec.

Behaviour:
- Reset: play=0, song=0, reset_player=0, beat=0, new_sample_generated=0, sample_out=0, voice_active=0, voice_load=0, voice_note=0, note_ready=0. Beat counter and mix register are cleared.
- Control FSM has two states, PAUSED (reset state) and PLAYING; play=1 only in PLAYING.
  - play_button toggles between the two states.
  - next_button or song_done: song<=song+1 (wraps at 2^SONG_W), state<=PAUSED, reset_player pulses one cycle, and all voices are cleared in that same cycle.
  - next_button or song_done coinciding with play_button: the next/done action wins and play_button is ignored.
- Frame sync:
  - Edge detection uses a registered copy of new_frame; a rising edge is new_frame & ~prev.
  - The cycle after the edge: new_sample_generated=1 for one cycle, and sample_out<=mix_reg if play=1, else 0.
- Mixer:
  - mix_reg is registered every cycle, giving 1 cycle latency from voice_samples.
  - It is the signed sum of the samples of active voices only, computed at SAMPLE_W+3 bits.
  - The sum saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- Beat:
  - The counter increments on new_sample_generated while play=1.
  - When the counter equals max(tempo_div,1)-1, it clears and beat pulses one cycle.
  - The counter holds while paused and clears on reset or on a reset_player pulse.
- Allocation:
  - note_ready = play & (at least one idle voice) & ~reset_player.
  - On acceptance, the lowest-index idle voice i takes the note: voice_note[i]<=note, remain[i]<=duration, voice_active[i]<=1, and voice_load[i] pulses the next cycle.
  - A note with duration=0 is consumed, allocates no voice, and produces no pulse.
- Countdown:
  - On beat, each active voice decrements remain; on the 1->0 transition, voice_active clears.
  - A voice freed by a beat is allocatable in the following cycle, not the same one.
  - Acceptance and a beat in the same cycle: the new note is not decremented by that beat.
- Registered outputs: all outputs are registered except note_ready, which is combinational from registered state.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- When defined: if all voices are busy, note_ready = play & ~reset_player. An accepted note steals the active voice with the smallest remain, lowest index on ties; voice_load pulses for that voice and remain is overwritten.
- When undefined: note_ready=0 whenever all voices are busy, which stalls the song reader.

Test Plan:
- Reset, then play_button pulse -> play=1, song=0. Second pulse -> play=0.
- tempo_div=4, play, 12 new_frame rising edges -> new_sample_generated 12 pulses, beat 3 pulses. With tempo_div=0 -> a beat every frame.
- Offer notes 10/d=2, 11/d=1, 12/d=0 -> voices 0 and 1 loaded, voice_load=0001 then 0010. Note 12 consumed, no load. Voice 1 idle after 1 beat, voice 0 idle after 2 beats.
- NUM_VOICES=4, all active at +30000, SAMPLE_W=16 -> sample_out=32767 at the next frame. With all at -30000 -> -32768. Paused -> sample_out=0.
- All voices busy, fifth note_valid -> note_ready=0 with the macro undefined. With VOICE_STEAL_EN and remain={5,2,2,7} -> voice 1 reloaded.
- next_button and play_button in the same cycle while PLAYING -> song=1, play=0, reset_player one pulse, voice_active=0. song_done at song=3 -> song=0.
